// File: rtl/demux1to16_ser.sv
// demux1to16_ser: serial-to-parallel demultiplexer, the receive side of a
// counter-driven 16:1 select mux link. Each valid bit is steered into the
// shadow slot chosen by an auto-incrementing select counter. A completed word
// is published on f together with a one-cycle done strobe.
//
// Optional build macro DMX_PARITY_EN: every frame carries one trailing
// even-parity bit. A PAR state collects that bit, and the perr output reports
// a parity mismatch alongside done.
module demux1to16_ser #(
    parameter int unsigned N  = 16,
    parameter int unsigned SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d,
    input  logic          v,
    input  logic          start,
    output logic [N-1:0]  f,
    output logic          done,
    output logic [SW-1:0] s,
`ifdef DMX_PARITY_EN
    output logic          perr,
`endif
    output logic          busy
);

    localparam logic [SW-1:0] SLOT_LAST = SW'(N - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

`ifdef DMX_PARITY_EN
    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_PAR  = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   perr_q,  perr_d;
`endif

    logic [SW-1:0] s_q,    s_d;
    logic [N-1:0]  sh_q,   sh_d;
    logic [N-1:0]  f_q,    f_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    // Write-side control: slot being addressed and whether a data bit lands
    logic          in_data_c;
    logic [SW-1:0] wr_slot_c;
    logic          wr_en_c;
    logic [N-1:0]  sel_oh_c;

    // Decode where the current bit goes; start forces slot 0
    always_comb begin
`ifdef DMX_PARITY_EN
        in_data_c = (state_q == ST_DATA);
`else
        in_data_c = 1'b1;
`endif
        wr_slot_c = start ? '0 : s_q;
        // In PAR the valid bit is the parity bit, not a data bit
        wr_en_c   = v && (start || in_data_c);
    end

    // One-hot slot decoder gating the shadow register write enables
    always_comb begin
        sel_oh_c            = '0;
        sel_oh_c[wr_slot_c] = 1'b1;
    end

    // Shadow register next value: only the selected slot takes d
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            sh_d[i] = (wr_en_c && sel_oh_c[i]) ? d : sh_q[i];
        end
    end

    // Next-state and output logic for counter, word publish and FSM
    always_comb begin
        s_d    = s_q;
        f_d    = f_q;
        done_d = 1'b0;
`ifdef DMX_PARITY_EN
        state_d = state_q;
        perr_d  = perr_q;
`endif

        if (start) begin
            // Frame sync drops any partial word; a bit with it lands in slot 0
            s_d = v ? SLOT_ONE : '0;
`ifdef DMX_PARITY_EN
            state_d = ST_DATA;
`endif
        end else if (v) begin
`ifdef DMX_PARITY_EN
            if (state_q == ST_PAR) begin
                // Parity bit closes the frame; s is already parked at 0
                f_d     = sh_q;
                done_d  = 1'b1;
                perr_d  = (^sh_q) ^ d;
                state_d = ST_DATA;
            end else begin
                s_d = s_q + SLOT_ONE;
                if (s_q == SLOT_LAST) begin
                    state_d = ST_PAR;
                end
            end
`else
            s_d = s_q + SLOT_ONE;
            if (s_q == SLOT_LAST) begin
                // Last bit bypasses the shadow so f and done appear together
                f_d    = {d, sh_q[N-2:0]};
                done_d = 1'b1;
            end
`endif
        end

`ifdef DMX_PARITY_EN
        busy_d = (s_d != '0) || (state_d == ST_PAR);
`else
        busy_d = (s_d != '0);
`endif
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            sh_q   <= '0;
            f_q    <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef DMX_PARITY_EN
            state_q <= ST_DATA;
            perr_q  <= 1'b0;
`endif
        end else begin
            s_q    <= s_d;
            sh_q   <= sh_d;
            f_q    <= f_d;
            done_q <= done_d;
            busy_q <= busy_d;
`ifdef DMX_PARITY_EN
            state_q <= state_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign f    = f_q;
    assign done = done_q;
    assign s    = s_q;
    assign busy = busy_q;
`ifdef DMX_PARITY_EN
    assign perr = perr_q;
`endif

endmodule

// File: tb/tb_demux1to16_ser.sv
// Directed testbench for demux1to16_ser; parity cases build with DMX_PARITY_EN.
module tb_demux1to16_ser;

    logic        clk;
    logic        rst;
    logic        d;
    logic        v;
    logic        start;
    logic [15:0] f;
    logic        done;
    logic [3:0]  s;
    logic        busy;
`ifdef DMX_PARITY_EN
    logic        perr;
`endif

    int checks;
    int failures;
    int done_cnt;

    demux1to16_ser #(.N(16), .SW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .d     (d),
        .v     (v),
        .start (start),
        .f     (f),
        .done  (done),
        .s     (s),
`ifdef DMX_PARITY_EN
        .perr  (perr),
`endif
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1ns after the edge, tally done pulses
    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
    endtask

    // Present one valid bit (optionally with start) for one cycle
    task automatic send(input logic b, input logic st);
        d = b; v = 1'b1; start = st;
        tick();
        v = 1'b0; start = 1'b0; d = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [15:0] w;
        checks = 0; failures = 0; done_cnt = 0;
        rst = 1'b1; d = 1'b0; v = 1'b0; start = 1'b0;
        idle(2);
        rst = 1'b0;
        chk("rst_f", 32'(f), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_s", 32'(s), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

`ifndef DMX_PARITY_EN
        // Frame A5C3 with v held high
        w = 16'hA5C3; done_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            send(w[k], 1'b0);
            if (k == 0) begin
                chk("a_s1", 32'(s), 32'h1);
                chk("a_busy1", 32'(busy), 32'h1);
            end
        end
        chk("a_f", 32'(f), 32'hA5C3);
        chk("a_done", 32'(done), 32'h1);
        chk("a_s", 32'(s), 32'h0);
        chk("a_busy", 32'(busy), 32'h0);
        idle(1);
        chk("a_done_drop", 32'(done), 32'h0);
        chk("a_f_hold", 32'(f), 32'hA5C3);
        chk("a_done_cnt", 32'(done_cnt), 32'h1);

        // Same word with 3 idle cycles after every bit
        done_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            send(w[k], 1'b0);
            idle(3);
            if (k == 4) chk("g_s_hold", 32'(s), 32'h5);
        end
        chk("g_f", 32'(f), 32'hA5C3);
        chk("g_done_cnt", 32'(done_cnt), 32'h1);

        // Back-to-back FFFF then 0001 without a gap
        done_cnt = 0;
        w = 16'hFFFF;
        for (int k = 0; k < 16; k++) send(w[k], 1'b0);
        chk("bb_f1", 32'(f), 32'hFFFF);
        chk("bb_done1", 32'(done), 32'h1);
        w = 16'h0001;
        for (int k = 0; k < 16; k++) begin
            send(w[k], 1'b0);
            if (k == 0) chk("bb_done_gap", 32'(done), 32'h0);
        end
        chk("bb_f2", 32'(f), 32'h0001);
        chk("bb_done2", 32'(done), 32'h1);
        chk("bb_done_cnt", 32'(done_cnt), 32'h2);

        // Abort after 7 bits of 1234 with start carrying bit 1 of 8001
        idle(1);
        done_cnt = 0;
        w = 16'h1234;
        for (int k = 0; k < 7; k++) send(w[k], 1'b0);
        chk("ab_s7", 32'(s), 32'h7);
        w = 16'h8001;
        send(w[0], 1'b1);
        chk("ab_done", 32'(done), 32'h0);
        chk("ab_s", 32'(s), 32'h1);
        chk("ab_f_hold", 32'(f), 32'h0001);
        for (int k = 1; k < 16; k++) send(w[k], 1'b0);
        chk("ab_f", 32'(f), 32'h8001);
        chk("ab_done_cnt", 32'(done_cnt), 32'h1);

        // start with v at slot 15: no word completes
        idle(1);
        done_cnt = 0;
        for (int k = 0; k < 15; k++) send(1'b1, 1'b0);
        chk("s15_s", 32'(s), 32'hF);
        send(1'b0, 1'b1);
        chk("s15_done", 32'(done), 32'h0);
        chk("s15_s1", 32'(s), 32'h1);
        chk("s15_f", 32'(f), 32'h8001);
        // start without v resets the slot only
        start = 1'b1; tick(); start = 1'b0;
        chk("st_s0", 32'(s), 32'h0);
        chk("st_busy", 32'(busy), 32'h0);
        chk("st_f", 32'(f), 32'h8001);
        chk("st_done_cnt", 32'(done_cnt), 32'h0);

        // Reset mid-frame, then 00FF
        for (int k = 0; k < 10; k++) send(1'b1, 1'b0);
        rst = 1'b1; d = 1'b1; v = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; v = 1'b0; start = 1'b0; d = 1'b0;
        chk("mr_f", 32'(f), 32'h0);
        chk("mr_s", 32'(s), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        done_cnt = 0;
        w = 16'h00FF;
        for (int k = 0; k < 16; k++) send(w[k], 1'b0);
        chk("mr_f2", 32'(f), 32'h00FF);
        idle(2);
        chk("mr_done_cnt", 32'(done_cnt), 32'h1);
`else
        // 0003 with even parity bit 0: no error
        done_cnt = 0;
        w = 16'h0003;
        for (int k = 0; k < 16; k++) send(w[k], 1'b0);
        chk("p1_done16", 32'(done), 32'h0);
        chk("p1_f16", 32'(f), 32'h0);
        chk("p1_s16", 32'(s), 32'h0);
        chk("p1_busy16", 32'(busy), 32'h1);
        send(1'b0, 1'b0);
        chk("p1_done", 32'(done), 32'h1);
        chk("p1_f", 32'(f), 32'h0003);
        chk("p1_perr", 32'(perr), 32'h0);
        chk("p1_busy", 32'(busy), 32'h0);

        // 0007 with parity bit 0: odd ones count flags an error
        w = 16'h0007;
        for (int k = 0; k < 16; k++) send(w[k], 1'b0);
        chk("p2_done16", 32'(done), 32'h0);
        chk("p2_f16", 32'(f), 32'h0003);
        chk("p2_perr16", 32'(perr), 32'h0);
        send(1'b0, 1'b0);
        chk("p2_done", 32'(done), 32'h1);
        chk("p2_f", 32'(f), 32'h0007);
        chk("p2_perr", 32'(perr), 32'h1);
        chk("p_done_cnt", 32'(done_cnt), 32'h2);

        // start during PAR aborts the frame
        done_cnt = 0;
        for (int k = 0; k < 16; k++) send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        chk("pa_done", 32'(done), 32'h0);
        chk("pa_s", 32'(s), 32'h1);
        chk("pa_f", 32'(f), 32'h0007);
        chk("pa_done_cnt", 32'(done_cnt), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux1to16_ser.md
Name: demux1to16_ser

Overview:
- Serial-to-parallel demultiplexer: the receive-side counterpart of the 16:1 select mux.
- Takes one data bit per qualified cycle and steers it into the output slot chosen by an internal auto-incrementing select counter.
- Presents a complete 16-bit word with a one-cycle done strobe once all slots are filled.
- Sits at the far end of a mux-based parallel-to-serial link and reconstructs the word that a counter-driven 16:1 mux sent out.

Parameters:
- N, 16, number of output slots (word width); must be a power of two.
- SW, 4, select/counter width; must equal log2(N).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  1  serial data bit.
- v  input  1  d is valid this cycle; a bit is consumed only when v=1.
- start  input  1  frame sync; forces the next slot to 0 and discards any partial word.
- f  output  N  last completed word, registered.
- done  output  1  one-cycle pulse when f is updated.
- s  output  SW  current slot index, i.e. where the next valid bit lands.
- busy  output  1  high while a partial word is held (s != 0, or in the parity state).

Behaviour:
- Reset, synchronous on rst=1 at the clk edge:
  - f=0, done=0, s=0, busy=0.
  - Shadow register sh=0; state=DATA.
  - rst overrides start and v; a partial word in flight is discarded.
- Bit ordering:
  - LSB first: the k-th valid bit of a frame lands in slot k (sh[k]).
  - Slot selection is a registered demux: the decoded one-hot of s gates the write enable of sh[s].
- DATA state, with v=1 and start=0:
  - sh[s] <= d; s <= s+1, wrapping modulo N.
  - If s==N-1: f <= {d, sh[N-2:0]} and done <= 1 on the same edge, so both are visible the cycle after the last bit. s wraps to 0.
- With v=0: no state change; done <= 0.
  - Gaps of any length between bits are legal; the partial word holds.
- done is high for exactly one cycle per completed word.
  - Back-to-back frames with v held high give done every N cycles, never merged.
- start=1 with v=0: s <= 0; sh is not cleared (stale bits are overwritten); f unchanged; done <= 0.
- start=1 with v=1: the bit is written to slot 0 and s <= 1, i.e. start takes priority over the counter value.
  - If s was N-1 at that edge, no word completes and done stays 0.
- f holds its value until the next completed word; it is never partially updated.
- busy = (s != 0) in DATA state; busy=1 in PAR state.
- Width rules:
  - s arithmetic is SW bits with natural wrap.
  - No combinational path from d to f.

Optional Feature:
- Macro DMX_PARITY_EN.
- When defined:
  - Each frame is N data bits followed by one even-parity bit.
  - After slot N-1 is written the FSM moves DATA->PAR instead of completing the word. s holds at 0.
  - In PAR, the next valid bit p completes the frame: f <= sh, done <= 1, perr <= ^sh ^ p (1 = parity error). The FSM returns to DATA.
  - Extra output port perr (1 bit, reset 0) updates only alongside done.
  - start in PAR aborts the frame: no done, back to DATA at slot 0 (or slot 1 if v=1).
- When undefined: no PAR state and no perr port; a frame is exactly N bits.

Test Plan:
- Reset then 16 consecutive valid bits of 16'hA5C3, LSB first -> f=16'hA5C3 and done=1 for exactly one cycle after the 16th bit; s returns to 0; busy=0.
- Same word with v low for 3 cycles between every bit -> same f=16'hA5C3, a single done pulse, s holds during gaps.
- Two back-to-back frames 16'hFFFF then 16'h0001, v held high -> done at cycles 16 and 32; f=16'hFFFF then 16'h0001.
- After 7 bits of 16'h1234, assert start with v=1 carrying bit 1, then 15 more bits completing 16'h8001 -> no done at the abort; final f=16'h8001.
- Assert rst after 10 bits of a frame, then send 16'h00FF -> f=0 and s=0 after reset; then f=16'h00FF with one done pulse.
- DMX_PARITY_EN: 16'h0003 + p=0 -> done, perr=0; 16'h0007 + p=0 -> done, perr=1; f updates only on the 17th bit.
